// File: rtl/spi_flash_pkg.sv
// Shared SPI flash opcodes, status masks and init FSM states.
// Imported by the init sequencer and the quad-read slave.
package spi_flash_pkg;

  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRSR2 = 8'h31;
  localparam logic [7:0] OP_RDSR1 = 8'h05;
  localparam logic [7:0] OP_RDSR2 = 8'h35;
  localparam logic [7:0] OP_FRQIO = 8'hEB;

  localparam logic [7:0] SR2_QE   = 8'h02;
  localparam logic [7:0] SR1_BUSY = 8'h01;

  typedef enum logic [3:0] {
    PWRUP,
    WREN,
    GAP1,
    WRSR2,
    GAP2,
    RDSR1,
    GAP3,
    RDSR2,
    DONE,
    ERROR
  } state_t;

endpackage

// File: rtl/spi_byte_shifter.sv
// Mode-0 SPI byte engine: one bit per two clocks, MSB first.
// A start during the last sck=1 cycle chains the next byte seamlessly.
module spi_byte_shifter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       io1_i,
  output logic       sck,
  output logic       io0_o,
  output logic [7:0] rx_byte,
  output logic       busy,
  output logic       done
);

  logic [6:0] tx_sr;
  logic [2:0] bit_cnt;

  assign done = busy & sck & (bit_cnt == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck     <= 1'b0;
      io0_o   <= 1'b0;
      rx_byte <= 8'h00;
      busy    <= 1'b0;
      tx_sr   <= 7'h00;
      bit_cnt <= 3'd0;
    end else begin
      if (busy && sck)
        rx_byte <= {rx_byte[6:0], io1_i};
      if (start) begin
        busy    <= 1'b1;
        sck     <= 1'b0;
        bit_cnt <= 3'd0;
        io0_o   <= tx_byte[7];
        tx_sr   <= tx_byte[6:0];
      end else if (busy) begin
        sck <= ~sck;
        if (sck) begin
          if (bit_cnt == 3'd7) begin
            busy  <= 1'b0;
            io0_o <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            io0_o   <= tx_sr[6];
            tx_sr   <= {tx_sr[5:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: rtl/spi_flash_init.sv
// Power-up sequencer: sets QE in SR2, polls BUSY, verifies QE,
// then hands the flash pins to the quad-read slave.
module spi_flash_init
  import spi_flash_pkg::*;
#(
  parameter int PWRUP_CYCLES  = 1024,
  parameter int CS_GAP_CYCLES = 4,
  parameter int POLL_MAX      = 1000
) (
  input  logic ACLK,
  input  logic ARESETn,
  output logic cs_n,
  output logic sck,
  output logic io0_o,
  input  logic io1_i,
  output logic io2_o,
  output logic io3_o,
  output logic io_oe,
  output logic init_done,
  output logic init_err
);

  localparam int CW = $clog2(PWRUP_CYCLES + CS_GAP_CYCLES + 1);
  localparam int PW = $clog2(POLL_MAX + 1);

  state_t        state;
  state_t        frame_next;
  logic [CW-1:0] cnt;
  logic [PW-1:0] polls;
  logic [PW-1:0] polls_nxt;
  logic [1:0]    sub;
  logic          bidx;

  logic       in_frame;
  logic       two_byte;
  logic [7:0] op_byte;
  logic [7:0] arg_byte;
  logic       sh_start;
  logic       sh_busy;
  logic       sh_done;
  logic [7:0] sh_tx;
  logic [7:0] sh_rx;

  assign io2_o = 1'b1;
  assign io3_o = 1'b1;

  assign polls_nxt = (polls == PW'(POLL_MAX)) ? polls : polls + 1'b1;

  always_comb begin
    in_frame   = 1'b0;
    two_byte   = 1'b1;
    op_byte    = 8'h00;
    arg_byte   = 8'h00;
    frame_next = state;
    case (state)
      WREN: begin
        in_frame   = 1'b1;
        two_byte   = 1'b0;
        op_byte    = OP_WREN;
        frame_next = GAP1;
      end
      WRSR2: begin
        in_frame   = 1'b1;
        op_byte    = OP_WRSR2;
        arg_byte   = SR2_QE;
        frame_next = GAP2;
      end
      RDSR1: begin
        in_frame = 1'b1;
        op_byte  = OP_RDSR1;
        if ((sh_rx & SR1_BUSY) == 8'h00)
          frame_next = GAP3;
        else if (polls_nxt < PW'(POLL_MAX))
          frame_next = GAP2;
        else
          frame_next = ERROR;
      end
      RDSR2: begin
        in_frame   = 1'b1;
        op_byte    = OP_RDSR2;
        frame_next = ((sh_rx & SR2_QE) != 8'h00) ? DONE : ERROR;
      end
      default: ;
    endcase
    // Byte 2 is launched in the last sck=1 cycle of byte 1
    sh_start = in_frame &&
               ((sub == 2'd1 && !sh_busy) ||
                (sub == 2'd2 && sh_done && two_byte && !bidx));
    sh_tx = (sub == 2'd1) ? op_byte : arg_byte;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state     <= PWRUP;
      cs_n      <= 1'b1;
      io_oe     <= 1'b1;
      init_done <= 1'b0;
      init_err  <= 1'b0;
      cnt       <= '0;
      polls     <= '0;
      sub       <= 2'd0;
      bidx      <= 1'b0;
    end else if (in_frame) begin
      case (sub)
        2'd1: begin
          sub  <= 2'd2;
          bidx <= 1'b0;
        end
        2'd2: if (sh_done) begin
          if (two_byte && !bidx)
            bidx <= 1'b1;
          else
            sub <= 2'd3;
        end
        2'd3: begin
          cs_n  <= 1'b1;
          sub   <= 2'd0;
          cnt   <= '0;
          state <= frame_next;
          if (state == RDSR1)
            polls <= polls_nxt;
          if (frame_next == DONE) begin
            init_done <= 1'b1;
            io_oe     <= 1'b0;
          end
          if (frame_next == ERROR)
            init_err <= 1'b1;
        end
        default: sub <= 2'd1;
      endcase
    end else begin
      case (state)
        PWRUP: begin
          if (cnt == CW'(PWRUP_CYCLES - 1)) begin
            cnt   <= '0;
            cs_n  <= 1'b0;
            sub   <= 2'd1;
            state <= WREN;
          end else
            cnt <= cnt + 1'b1;
        end
        GAP1, GAP2, GAP3: begin
          if (cnt == CW'(CS_GAP_CYCLES - 1)) begin
            cnt  <= '0;
            cs_n <= 1'b0;
            sub  <= 2'd1;
            case (state)
              GAP1:    state <= WRSR2;
              GAP2:    state <= RDSR1;
              default: state <= RDSR2;
            endcase
          end else
            cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  spi_byte_shifter u_shift (
    .clk     (ACLK),
    .rst_n   (ARESETn),
    .start   (sh_start),
    .tx_byte (sh_tx),
    .io1_i   (io1_i),
    .sck     (sck),
    .io0_o   (io0_o),
    .rx_byte (sh_rx),
    .busy    (sh_busy),
    .done    (sh_done)
  );

endmodule

// File: tb/tb_spi_flash_init.sv
// Directed bench for spi_flash_init with a behavioural status-register flash.
// Frames are logged as {8'h0, opcode, second byte, cs_n low cycles}.
module tb_spi_flash_init;

  logic ACLK    = 1'b0;
  logic ARESETn = 1'b0;
  logic io1_i   = 1'b0;
  logic cs_n, sck, io0_o, io2_o, io3_o, io_oe, init_done, init_err;

  always #5 ACLK = ~ACLK;

  spi_flash_init #(
    .PWRUP_CYCLES  (8),
    .CS_GAP_CYCLES (4),
    .POLL_MAX      (5)
  ) dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .cs_n      (cs_n),
    .sck       (sck),
    .io0_o     (io0_o),
    .io1_i     (io1_i),
    .io2_o     (io2_o),
    .io3_o     (io3_o),
    .io_oe     (io_oe),
    .init_done (init_done),
    .init_err  (init_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int          bitcnt     = 0;
  int          low_cnt    = 0;
  int          gap_cnt    = 0;
  int          min_gap    = 1000;
  int          rdsr1_seen = 0;
  int          nbusy      = 0;
  int          viol       = 0;
  logic [7:0]  sr2_val    = 8'h02;
  logic [7:0]  op         = 8'h00;
  logic [15:0] rx         = 16'h0;
  logic        was_low    = 1'b0;
  logic        seen_frame = 1'b0;
  logic        last_io0   = 1'b0;
  logic [31:0] frames[$];

  function automatic logic rd_bit();
    logic [7:0] r;
    r = 8'h00;
    if (op == 8'h05)
      r = (rdsr1_seen < nbusy) ? 8'h01 : 8'h5C;
    else if (op == 8'h35)
      r = sr2_val;
    if (bitcnt >= 8 && bitcnt < 16)
      return r[15-bitcnt];
    return 1'b0;
  endfunction

  function automatic logic [31:0] fr(int i);
    return (i < frames.size()) ? frames[i] : 32'hFFFF_FFFF;
  endfunction

  // Flash model and pin checker, evaluated mid-cycle
  initial forever begin
    @(negedge ACLK);
    if (io2_o !== 1'b1 || io3_o !== 1'b1) viol++;
    if (cs_n && (sck || io0_o)) viol++;
    if (sck && io0_o !== last_io0) viol++;
    if (init_done && init_err) viol++;
    last_io0 = io0_o;
    if (!cs_n) begin
      if (!was_low) begin
        if (seen_frame && gap_cnt < min_gap) min_gap = gap_cnt;
        bitcnt  = 0;
        rx      = 16'h0;
        low_cnt = 0;
        op      = 8'h00;
      end
      was_low = 1'b1;
      low_cnt++;
      if (!sck)
        io1_i = rd_bit();
      else begin
        rx = {rx[14:0], io0_o};
        bitcnt++;
        if (bitcnt == 8) op = rx[7:0];
      end
    end else begin
      if (was_low) begin
        frames.push_back({8'h00, op,
                          (bitcnt == 16) ? rx[7:0] : 8'h00,
                          8'(low_cnt)});
        if (op == 8'h05) rdsr1_seen++;
        seen_frame = 1'b1;
        gap_cnt    = 0;
      end
      was_low = 1'b0;
      gap_cnt++;
      io1_i = 1'b0;
    end
  end

  task automatic run_reset(string tag, int nb, logic [7:0] s2);
    int n;
    ARESETn = 1'b0;
    repeat (3) @(negedge ACLK);
    #1;
    chk({tag, "_rst_cs_n"}, cs_n, 1);
    chk({tag, "_rst_sck"}, sck, 0);
    chk({tag, "_rst_io0"}, io0_o, 0);
    chk({tag, "_rst_oe"}, io_oe, 1);
    chk({tag, "_rst_flags"}, {init_done, init_err}, 0);
    frames.delete();
    rdsr1_seen = 0;
    nbusy      = nb;
    sr2_val    = s2;
    min_gap    = 1000;
    seen_frame = 1'b0;
    was_low    = 1'b0;
    viol       = 0;
    ARESETn    = 1'b1;
    n = 0;
    while (n < 50) begin
      @(posedge ACLK);
      #1;
      n++;
      if (!cs_n) break;
    end
    chk({tag, "_pwrup_edges"}, n, 8);
  endtask

  task automatic wait_end(string tag);
    int k;
    k = 0;
    while (!(init_done || init_err) && k < 4000) begin
      @(negedge ACLK);
      k++;
    end
    chk({tag, "_timeout"}, k < 4000, 1);
    repeat (10) @(negedge ACLK);
    #1;
  endtask

  task automatic chk_done(string tag);
    chk({tag, "_done"}, init_done, 1);
    chk({tag, "_err"}, init_err, 0);
    chk({tag, "_oe"}, io_oe, 0);
    chk({tag, "_idle"}, {cs_n, sck}, 2'b10);
  endtask

  task automatic chk_err(string tag);
    chk({tag, "_done"}, init_done, 0);
    chk({tag, "_err"}, init_err, 1);
    chk({tag, "_oe"}, io_oe, 1);
    chk({tag, "_idle"}, {cs_n, sck}, 2'b10);
  endtask

  initial begin
    int n35;
    int k;

    // Nominal bring-up
    run_reset("t1", 0, 8'h02);
    wait_end("t1");
    chk("t1_nfr", frames.size(), 4);
    chk("t1_wren", fr(0), 32'h0006_0012);
    chk("t1_wrsr2", fr(1), 32'h0031_0222);
    chk("t1_rdsr1", fr(2), 32'h0005_0022);
    chk("t1_rdsr2", fr(3), 32'h0035_0022);
    chk("t1_gap", min_gap >= 4, 1);
    chk_done("t1");
    chk("t1_viol", viol, 0);

    // Three busy polls before ready
    run_reset("t2", 3, 8'h02);
    wait_end("t2");
    chk("t2_nfr", frames.size(), 7);
    chk("t2_polls", rdsr1_seen, 4);
    chk("t2_poll4", fr(5), 32'h0005_0022);
    chk("t2_rdsr2", fr(6), 32'h0035_0022);
    chk_done("t2");
    chk("t2_viol", viol, 0);

    // BUSY stuck: timeout after POLL_MAX polls
    run_reset("t3", 100, 8'h02);
    wait_end("t3");
    n35 = 0;
    foreach (frames[i])
      if (frames[i][23:16] == 8'h35) n35++;
    chk("t3_nfr", frames.size(), 7);
    chk("t3_polls", rdsr1_seen, 5);
    chk("t3_no_rdsr2", n35, 0);
    chk_err("t3");
    chk("t3_viol", viol, 0);

    // QE not set on readback
    run_reset("t4", 0, 8'h00);
    wait_end("t4");
    chk("t4_nfr", frames.size(), 4);
    chk("t4_rdsr2", fr(3), 32'h0035_0022);
    chk_err("t4");
    chk("t4_viol", viol, 0);

    // Reset during the 2nd bit of WRSR2
    run_reset("t5", 0, 8'h02);
    k = 0;
    while (k < 500) begin
      @(negedge ACLK);
      #1;
      k++;
      if (frames.size() == 1 && !cs_n && bitcnt == 1 && !sck) break;
    end
    chk("t5_reached", k < 500, 1);
    chk("t5_pre_cs", cs_n, 0);
    ARESETn = 1'b0;
    #1;
    chk("t5_abort_cs", cs_n, 1);
    chk("t5_abort_sck", sck, 0);
    run_reset("t5b", 0, 8'h02);
    wait_end("t5b");
    chk("t5_nfr", frames.size(), 4);
    chk("t5_wren", fr(0), 32'h0006_0012);
    chk("t5_wrsr2", fr(1), 32'h0031_0222);
    chk("t5_rdsr1", fr(2), 32'h0005_0022);
    chk("t5_rdsr2", fr(3), 32'h0035_0022);
    chk_done("t5");
    chk("t5_viol", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
